// File: rtl/textprint_pkg.sv
// textprint_pkg: shared types and character constants for the text-print controller.
//   tp_state_t - controller FSM states
//   CH_*       - control character codes recognised by the controller
package textprint_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StScrRd,
    StScrWr,
    StBlank,
    StClear
  } tp_state_t;

  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding queued character codes.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write request and data (accepted when not full, or full with a pop)
//   pop        : read request (ignored when empty)
//   full, empty: occupancy flags
//   head       : oldest entry, valid while not empty
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/textprint_ctrl.sv
// textprint_ctrl: queues character codes from the core and performs the resulting
// character-map writes (print, newline, backspace, clear screen, scroll).
//   clk, reset           : clock, asynchronous active-high reset
//   textprint, chardata  : one-cycle strobe pushing a character code
//   busy                 : work queued or in progress
//   overflow             : sticky, a strobe was dropped on a full queue
//   cm_req/we/adr/wdata  : character-map transfer request, held until cm_ack
//   cm_rdata, cm_ack     : read data and transfer completion
//   cursor_col/row       : current text cursor
module textprint_ctrl
  import textprint_pkg::*;
#(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     textprint,
  input  logic [7:0]               chardata,
  output logic                     busy,
  output logic                     overflow,
  output logic                     cm_req,
  output logic                     cm_we,
  output logic [ADDR_W-1:0]        cm_adr,
  output logic [7:0]               cm_wdata,
  input  logic [7:0]               cm_rdata,
  input  logic                     cm_ack,
  output logic [$clog2(COLS)-1:0]  cursor_col,
  output logic [$clog2(ROWS)-1:0]  cursor_row
);

  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned RowW = $clog2(ROWS);

  localparam logic [ColW-1:0]   LastCol    = ColW'(COLS - 1);
  localparam logic [RowW-1:0]   LastRow    = RowW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] BlankStart = ADDR_W'((ROWS - 1) * COLS);

  tp_state_t         state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        rd_latch_q, rd_latch_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              overflow_q;

  logic              fifo_full, fifo_empty, pop;
  logic [7:0]        fifo_head;
  logic [ADDR_W-1:0] cur_adr;

  cmd_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk  (clk),
    .reset(reset),
    .push (textprint),
    .din  (chardata),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  assign cur_adr    = ADDR_W'(row_q) * ColsA + ADDR_W'(col_q);
  assign busy       = !fifo_empty || (state_q != StIdle);
  assign overflow   = overflow_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    rd_latch_d = rd_latch_q;
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    cm_req     = 1'b0;
    cm_we      = 1'b0;
    cm_adr     = '0;
    cm_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cmd_d = fifo_head;
          case (fifo_head)
            CH_NL: begin
              col_d = '0;
              if (row_q == LastRow) begin
                state_d = StScrRd;
                idx_d   = ColsA;
              end else begin
                row_d = row_q + RowW'(1);
              end
            end
            CH_CR: col_d = '0;
            CH_BS: begin
              if (col_q != '0) begin
                col_d = col_q - ColW'(1);
              end else if (row_q != '0) begin
                col_d = LastCol;
                row_d = row_q - RowW'(1);
              end
            end
            CH_FF: begin
              state_d = StClear;
              idx_d   = '0;
            end
            default: state_d = StWrite;
          endcase
        end
      end

      StWrite: begin
        cm_req   = 1'b1;
        cm_we    = 1'b1;
        cm_adr   = cur_adr;
        cm_wdata = cmd_q;
        if (cm_ack) begin
          state_d = StIdle;
          if (col_q == LastCol) begin
            // Writing the last column behaves like a newline.
            col_d = '0;
            if (row_q == LastRow) begin
              state_d = StScrRd;
              idx_d   = ColsA;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end

      StScrRd: begin
        cm_req = 1'b1;
        cm_adr = idx_q;
        if (cm_ack) begin
          rd_latch_d = cm_rdata;
          state_d    = StScrWr;
        end
      end

      StScrWr: begin
        cm_req   = 1'b1;
        cm_we    = 1'b1;
        cm_adr   = idx_q - ColsA;
        cm_wdata = rd_latch_q;
        if (cm_ack) begin
          if (idx_q == LastIdx) begin
            state_d = StBlank;
            idx_d   = BlankStart;
          end else begin
            state_d = StScrRd;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end

      StBlank, StClear: begin
        cm_req   = 1'b1;
        cm_we    = 1'b1;
        cm_adr   = idx_q;
        cm_wdata = CH_SPACE;
        if (cm_ack) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            col_d   = '0;
            if (state_q == StClear) row_d = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      rd_latch_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rd_latch_q <= rd_latch_d;
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      if (textprint && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule
